alarm_slot_scheduler: RTL and testbench

Multi-slot alarm scheduler that sits in front of the alarm-check/minigame service. It holds NSLOT programmable alarm times and detects which enabled slot matches the current BCD clock on each minute tick. It presents one slot at a time as the service's alarm time, and sequences completion, snooze and cancellation.

---
 rtl/alarm_slot_scheduler.sv | 215 +++++++++++++++++++++
 tb/tb_alarm_slot_scheduler.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/alarm_slot_scheduler.sv
// alarm_slot_scheduler
// Holds NSLOT programmable BCD alarm times, flags enabled slots that match the
// current time on each minute tick, and presents one pending slot at a time to
// the alarm-check/minigame service. Ring episodes end on done, snooze or cancel
// (slot disabled while ringing).
//
// Build option: define ALARM_SNOOZE_EN to include the per-slot snooze time,
// snooze flag, snooze counter and BCD minute adder. When it is undefined,
// snooze is ignored and snooze_cnt is held at 0.
//
// Ports:
//   s2clk        system clock
//   reset        asynchronous, active-high reset
//   wr_en        one-cycle strobe, writes wr_time into slot wr_slot
//   wr_slot      target slot index
//   wr_time      BCD {Ht,Ho,Mt,Mo} alarm time
//   slot_en      per-slot enable switches
//   current      current BCD time
//   minute_tick  pulse on the first cycle of a new current value
//   snooze       one-cycle snooze request
//   done         one-cycle "minigame finished" pulse
//   alarm_time   effective time of the ringing slot, 0 when idle
//   alarm_active high while ringing
//   active_slot  index of the ringing slot, 0 when idle
//   snooze_cnt   snoozes used in the current episode
//   pending      slots matched but not yet serviced
module alarm_slot_scheduler #(
   parameter int NSLOT      = 4,
   parameter int SNOOZE_MIN = 5,
   parameter int MAX_SNOOZE = 3
) (
   input  logic        s2clk,
   input  logic        reset,
   input  logic        wr_en,
   input  logic [1:0]  wr_slot,
   input  logic [15:0] wr_time,
   input  logic [3:0]  slot_en,
   input  logic [15:0] current,
   input  logic        minute_tick,
   input  logic        snooze,
   input  logic        done,
   output logic [15:0] alarm_time,
   output logic        alarm_active,
   output logic [1:0]  active_slot,
   output logic [1:0]  snooze_cnt,
   output logic [3:0]  pending
);

   typedef enum logic {IDLE, RING} state_t;

   state_t            state, state_nxt;
   logic [15:0]       slot_time [NSLOT];
   logic [15:0]       eff_time  [NSLOT];
   logic [NSLOT-1:0]  match;
   logic [NSLOT-1:0]  service_mask;
   logic [1:0]        sel_slot;
   logic              ring_enter;
   logic              ring_clear;
   logic              snooze_take;

`ifdef ALARM_SNOOZE_EN
   logic [NSLOT-1:0]  snz_flag;
   logic [15:0]       snz_time [NSLOT];
   logic [1:0]        snz_cnt  [NSLOT];
   logic [15:0]       snooze_target;

   // Adds SNOOZE_MIN minutes to a valid BCD HH:MM, carrying into the hour and
   // wrapping hour 24 back to 00.
   function automatic logic [15:0] bcd_add_min(input logic [15:0] t);
      logic [6:0] m;
      logic [5:0] h;
      m = 7'(t[7:4]) * 7'd10 + 7'(t[3:0]) + 7'(SNOOZE_MIN);
      h = 6'(t[15:12]) * 6'd10 + 6'(t[11:8]);
      if (m >= 7'd60) begin
         m = m - 7'd60;
         h = h + 6'd1;
      end
      if (h == 6'd24) h = 6'd0;
      return {4'(h / 6'd10), 4'(h % 6'd10), 4'(m / 7'd10), 4'(m % 7'd10)};
   endfunction

   assign snooze_target = bcd_add_min(current);
`else
   logic unused_cfg;
   assign unused_cfg = ^{snooze, 7'(SNOOZE_MIN), 2'(MAX_SNOOZE)};
`endif

   // A snoozed slot rings again at its snooze time instead of its programmed time.
   always_comb begin
      for (int i = 0; i < NSLOT; i++) begin
`ifdef ALARM_SNOOZE_EN
         eff_time[i] = snz_flag[i] ? snz_time[i] : slot_time[i];
`else
         eff_time[i] = slot_time[i];
`endif
      end
   end

   // Matches are only taken on the tick; the ringing slot is excluded so it
   // cannot re-arm itself while it is being serviced.
   always_comb begin
      match = '0;
      for (int i = 0; i < NSLOT; i++) begin
         if (minute_tick && slot_en[i] && (eff_time[i] == current) &&
             !((state == RING) && (active_slot == 2'(i))))
            match[i] = 1'b1;
      end
   end

   // Lowest pending index wins when several slots are waiting.
   always_comb begin
      sel_slot = 2'd0;
      for (int i = NSLOT - 1; i >= 0; i--) begin
         if (pending[i]) sel_slot = 2'(i);
      end
   end

   // Next-state logic. done and cancel take priority over snooze.
   always_comb begin
      state_nxt   = state;
      ring_enter  = 1'b0;
      ring_clear  = 1'b0;
      snooze_take = 1'b0;
      case (state)
         IDLE: begin
            if (pending != '0) begin
               state_nxt  = RING;
               ring_enter = 1'b1;
            end
         end
         RING: begin
            if (done || !slot_en[active_slot]) begin
               ring_clear = 1'b1;
               state_nxt  = IDLE;
            end
`ifdef ALARM_SNOOZE_EN
            else if (snooze && (snz_cnt[active_slot] < 2'(MAX_SNOOZE))) begin
               snooze_take = 1'b1;
               state_nxt   = IDLE;
            end
`endif
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign service_mask = (ring_clear || snooze_take) ? (NSLOT'(1) << active_slot) : '0;

   always_ff @(posedge s2clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_nxt;
   end

   // Slot storage, pending bits and the registered service-facing outputs.
   // A write on a slot lands after any snooze update so the fresh time wins.
   always_ff @(posedge s2clk or posedge reset) begin
      if (reset) begin
         for (int i = 0; i < NSLOT; i++) begin
            slot_time[i] <= 16'h0000;
`ifdef ALARM_SNOOZE_EN
            snz_time[i] <= 16'h0000;
            snz_cnt[i]  <= 2'd0;
`endif
         end
`ifdef ALARM_SNOOZE_EN
         snz_flag <= '0;
`endif
         pending      <= '0;
         alarm_time   <= 16'h0000;
         alarm_active <= 1'b0;
         active_slot  <= 2'd0;
         snooze_cnt   <= 2'd0;
      end else begin
         pending <= (pending | match) & slot_en & ~service_mask;
         for (int i = 0; i < NSLOT; i++) begin
`ifdef ALARM_SNOOZE_EN
            if (!slot_en[i] || (ring_clear && (active_slot == 2'(i)))) begin
               snz_flag[i] <= 1'b0;
               snz_cnt[i]  <= 2'd0;
            end else if (snooze_take && (active_slot == 2'(i))) begin
               snz_flag[i] <= 1'b1;
               snz_time[i] <= snooze_target;
               snz_cnt[i]  <= snz_cnt[i] + 2'd1;
            end
            if (wr_en && (wr_slot == 2'(i))) begin
               snz_flag[i] <= 1'b0;
               snz_cnt[i]  <= 2'd0;
            end
`endif
            if (wr_en && (wr_slot == 2'(i)))
               slot_time[i] <= wr_time;
         end

         if (ring_enter) begin
            alarm_active <= 1'b1;
            active_slot  <= sel_slot;
            alarm_time   <= eff_time[sel_slot];
`ifdef ALARM_SNOOZE_EN
            snooze_cnt   <= snz_cnt[sel_slot];
`endif
         end else if (ring_clear || snooze_take) begin
            alarm_active <= 1'b0;
            active_slot  <= 2'd0;
            alarm_time   <= 16'h0000;
`ifdef ALARM_SNOOZE_EN
            snooze_cnt   <= snooze_take ? (snz_cnt[active_slot] + 2'd1) : 2'd0;
`endif
         end
`ifndef ALARM_SNOOZE_EN
         snooze_cnt <= 2'd0;
`endif
      end
   end

endmodule

// File: tb/tb_alarm_slot_scheduler.sv
// Directed testbench for alarm_slot_scheduler. Inputs change 1 time unit after
// each rising edge and outputs are checked at that same point, well away from
// the next edge. Snooze scenarios follow the ALARM_SNOOZE_EN build option.
module tb_alarm_slot_scheduler;

   logic        s2clk = 1'b0;
   logic        reset;
   logic        wr_en;
   logic [1:0]  wr_slot;
   logic [15:0] wr_time;
   logic [3:0]  slot_en;
   logic [15:0] current;
   logic        minute_tick;
   logic        snooze;
   logic        done;
   logic [15:0] alarm_time;
   logic        alarm_active;
   logic [1:0]  active_slot;
   logic [1:0]  snooze_cnt;
   logic [3:0]  pending;

   int n_compared   = 0;
   int n_mismatched = 0;

   alarm_slot_scheduler dut (
      .s2clk        (s2clk),
      .reset        (reset),
      .wr_en        (wr_en),
      .wr_slot      (wr_slot),
      .wr_time      (wr_time),
      .slot_en      (slot_en),
      .current      (current),
      .minute_tick  (minute_tick),
      .snooze       (snooze),
      .done         (done),
      .alarm_time   (alarm_time),
      .alarm_active (alarm_active),
      .active_slot  (active_slot),
      .snooze_cnt   (snooze_cnt),
      .pending      (pending)
   );

   always #5 s2clk = ~s2clk;

   task automatic checkOutput(input string tag, input logic [15:0] observed, input logic [15:0] expected);
      n_compared++;
      if (observed !== expected) begin
         n_mismatched++;
         $display("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
      end
   endtask

   task automatic stepCycle();
      @(posedge s2clk);
      #1;
   endtask

   task automatic writeSlot(input logic [1:0] slot, input logic [15:0] t);
      wr_en = 1'b1; wr_slot = slot; wr_time = t;
      stepCycle();
      wr_en = 1'b0;
   endtask

   task automatic tickAt(input logic [15:0] t);
      current = t; minute_tick = 1'b1;
      stepCycle();
      minute_tick = 1'b0;
   endtask

   task automatic pulseDone();
      done = 1'b1;
      stepCycle();
      done = 1'b0;
   endtask

   task automatic pulseSnooze();
      snooze = 1'b1;
      stepCycle();
      snooze = 1'b0;
   endtask

   initial begin
      reset = 1'b1; wr_en = 1'b0; wr_slot = 2'd0; wr_time = 16'h0000;
      slot_en = 4'b0000; current = 16'h0000; minute_tick = 1'b0;
      snooze = 1'b0; done = 1'b0;
      stepCycle();
      stepCycle();
      checkOutput("reset_alarm_time", alarm_time, 16'h0000);
      checkOutput("reset_active", 16'(alarm_active), 16'h0);
      checkOutput("reset_pending", 16'(pending), 16'h0);
      reset = 1'b0;
      stepCycle();

      // Single slot ring: slot1 at 07:30.
      writeSlot(2'd1, 16'h0730);
      slot_en = 4'b0010;
      tickAt(16'h0730);
      checkOutput("t1_pending", 16'(pending), 16'h0002);
      checkOutput("t1_not_yet_active", 16'(alarm_active), 16'h0);
      stepCycle();
      checkOutput("t1_active", 16'(alarm_active), 16'h1);
      checkOutput("t1_slot", 16'(active_slot), 16'h1);
      checkOutput("t1_time", alarm_time, 16'h0730);
      pulseDone();
      checkOutput("t1_done_active", 16'(alarm_active), 16'h0);
      checkOutput("t1_done_pending", 16'(pending), 16'h0);
      checkOutput("t1_done_time", alarm_time, 16'h0000);
      stepCycle();
      checkOutput("t1_stays_idle", 16'(alarm_active), 16'h0);

      // Disabled slot never matches.
      slot_en = 4'b0000;
      tickAt(16'h0730);
      checkOutput("disabled_no_pending", 16'(pending), 16'h0);

      // Two slots at 06:00: slot0 first, one idle cycle, then slot2.
      writeSlot(2'd0, 16'h0600);
      writeSlot(2'd2, 16'h0600);
      slot_en = 4'b0101;
      tickAt(16'h0600);
      checkOutput("t2_pending", 16'(pending), 16'h0005);
      stepCycle();
      checkOutput("t2_ring0_active", 16'(alarm_active), 16'h1);
      checkOutput("t2_ring0_slot", 16'(active_slot), 16'h0);
      checkOutput("t2_ring0_time", alarm_time, 16'h0600);
      pulseDone();
      checkOutput("t2_gap_active", 16'(alarm_active), 16'h0);
      checkOutput("t2_gap_pending", 16'(pending), 16'h0004);
      stepCycle();
      checkOutput("t2_ring2_active", 16'(alarm_active), 16'h1);
      checkOutput("t2_ring2_slot", 16'(active_slot), 16'h2);
      pulseDone();
      checkOutput("t2_end_pending", 16'(pending), 16'h0);
      checkOutput("t2_end_slot", 16'(active_slot), 16'h0);

      // Write on the ringing slot keeps the latched time, then cancel by disable.
      slot_en = 4'b0010;
      tickAt(16'h0730);
      stepCycle();
      checkOutput("t5_ring_active", 16'(alarm_active), 16'h1);
      writeSlot(2'd1, 16'h0800);
      checkOutput("t5_write_keeps_ring", 16'(alarm_active), 16'h1);
      checkOutput("t5_write_keeps_time", alarm_time, 16'h0730);
      slot_en = 4'b0000;
      stepCycle();
      checkOutput("t5_cancel_active", 16'(alarm_active), 16'h0);
      checkOutput("t5_cancel_pending", 16'(pending), 16'h0);

      // New time on slot1 fires; reset mid-ring clears outputs without a clock edge.
      slot_en = 4'b0010;
      tickAt(16'h0800);
      stepCycle();
      checkOutput("t6_ring_time", alarm_time, 16'h0800);
      reset = 1'b1;
      #2;
      checkOutput("t6_rst_active", 16'(alarm_active), 16'h0);
      checkOutput("t6_rst_time", alarm_time, 16'h0000);
      checkOutput("t6_rst_slot", 16'(active_slot), 16'h0);
      checkOutput("t6_rst_pending", 16'(pending), 16'h0);
      reset = 1'b0;
      stepCycle();

      // Slot times are back to 00:00 after reset.
      slot_en = 4'b0001;
      tickAt(16'h0000);
      checkOutput("t7_pending", 16'(pending), 16'h0001);
      stepCycle();
      checkOutput("t7_active", 16'(alarm_active), 16'h1);
      checkOutput("t7_time", alarm_time, 16'h0000);

`ifdef ALARM_SNOOZE_EN
      pulseDone();
      // Snooze at 23:58 wraps to 00:03; counter tops out at three.
      writeSlot(2'd3, 16'h2358);
      slot_en = 4'b1000;
      tickAt(16'h2358);
      stepCycle();
      checkOutput("s_ring_time", alarm_time, 16'h2358);
      pulseSnooze();
      checkOutput("s1_active", 16'(alarm_active), 16'h0);
      checkOutput("s1_cnt", 16'(snooze_cnt), 16'h1);
      checkOutput("s1_pending", 16'(pending), 16'h0);
      tickAt(16'h2359);
      tickAt(16'h0000);
      tickAt(16'h0001);
      tickAt(16'h0002);
      stepCycle();
      checkOutput("s1_quiet_active", 16'(alarm_active), 16'h0);
      checkOutput("s1_quiet_pending", 16'(pending), 16'h0);
      tickAt(16'h0003);
      stepCycle();
      checkOutput("s1_ring_active", 16'(alarm_active), 16'h1);
      checkOutput("s1_ring_time", alarm_time, 16'h0003);
      checkOutput("s1_ring_cnt", 16'(snooze_cnt), 16'h1);
      pulseSnooze();
      checkOutput("s2_cnt", 16'(snooze_cnt), 16'h2);
      tickAt(16'h0008);
      stepCycle();
      checkOutput("s2_ring_time", alarm_time, 16'h0008);
      pulseSnooze();
      checkOutput("s3_cnt", 16'(snooze_cnt), 16'h3);
      tickAt(16'h0013);
      stepCycle();
      checkOutput("s3_ring_time", alarm_time, 16'h0013);
      pulseSnooze();
      checkOutput("s4_ignored_active", 16'(alarm_active), 16'h1);
      checkOutput("s4_ignored_cnt", 16'(snooze_cnt), 16'h3);
      done = 1'b1; snooze = 1'b1;
      stepCycle();
      done = 1'b0; snooze = 1'b0;
      checkOutput("s_done_wins_active", 16'(alarm_active), 16'h0);
      checkOutput("s_done_wins_cnt", 16'(snooze_cnt), 16'h0);
`else
      // Without the snooze option a snooze pulse leaves the ring untouched.
      pulseSnooze();
      checkOutput("ns_active", 16'(alarm_active), 16'h1);
      checkOutput("ns_cnt", 16'(snooze_cnt), 16'h0);
      pulseSnooze();
      checkOutput("ns_active2", 16'(alarm_active), 16'h1);
      pulseDone();
      checkOutput("ns_done_active", 16'(alarm_active), 16'h0);
`endif

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
      $finish;
   end

endmodule
